// File: rtl/afifo_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Package     : afifo_pkg
// Description : Shared constants and helpers for the asynchronous FIFO
//               read-side logic. Holds the default entry width and packing
//               ratio, plus the width function for the lane counter.
// Revision    : 1.0 - initial release
// ============================================================================
package afifo_pkg;

    // Default FIFO entry width in bits.
    localparam int C_DEFAULT_WIDTH = 8;

    // Default number of FIFO entries packed into one output word.
    localparam int C_DEFAULT_RATIO = 4;

    // The lane counter must represent 0..ratio inclusive. The value ratio
    // itself marks a complete word that is waiting for the output register.
    function automatic int cnt_width(input int ratio);
        return $clog2(ratio + 1);
    endfunction

endpackage : afifo_pkg
`default_nettype wire

// File: rtl/afifo_rd_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : afifo_rd_packer
// Description : Read-domain consumer of the asynchronous FIFO. Pops entries,
//               captures them from the FIFO's registered read data and packs
//               RATIO consecutive entries little-endian into one output word
//               presented on a valid/ready stream. A flush request emits the
//               partially assembled word with a lane-keep mask.
// Revision    : 1.0 - initial release
//
// Ports:
//   rclk      in   read-domain clock (rising edge)
//   rrstn     in   asynchronous active-low reset
//   rempty    in   FIFO empty flag
//   rinc      out  FIFO pop request (combinational)
//   rdata     in   FIFO read data, valid the cycle after an accepted pop
//   flush     in   single-cycle request to emit the partial word
//   out_valid out  output word valid
//   out_ready in   downstream accept
//   out_data  out  packed word, lane 0 in the LSBs
//   out_keep  out  lane-valid mask
// ============================================================================
module afifo_rd_packer
    import afifo_pkg::*;
#(
    parameter int WIDTH = C_DEFAULT_WIDTH,
    parameter int RATIO = C_DEFAULT_RATIO
) (
    input  logic                   rclk,
    input  logic                   rrstn,
    input  logic                   rempty,
    output logic                   rinc,
    input  logic [WIDTH-1:0]       rdata,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH*RATIO-1:0] out_data,
    output logic [RATIO-1:0]       out_keep
);

    localparam int CW = cnt_width(RATIO);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [RATIO-1:0][WIDTH-1:0] asm_q, asm_d;        // assembly lanes
    logic [CW-1:0]               cnt_q, cnt_d;        // lanes filled
    logic                        rd_pend_q, rd_pend_d;
    logic                        flush_pend_q, flush_pend_d;
    logic                        out_valid_q, out_valid_d;
    logic [WIDTH*RATIO-1:0]      out_data_q, out_data_d;
    logic [RATIO-1:0]            out_keep_q, out_keep_d;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic          slot_free_w;
    logic [CW:0]   fill_w;        // lanes filled plus the byte in flight
    logic          pop_ok_w;
    logic          word_full_w;
    logic          flush_req_w;
    logic          flush_serve_w;

    assign slot_free_w = !out_valid_q || out_ready;

    // One extra bit so cnt == RATIO plus an in-flight byte cannot wrap.
    assign fill_w = {1'b0, cnt_q} + {{CW{1'b0}}, rd_pend_q};

    // Pop when there is room for the byte that would return next cycle.
    // The last lane may be popped early only if the finished word can move
    // straight into the output register, which keeps full rate across word
    // boundaries without overrunning the assembly register.
    assign pop_ok_w = (fill_w < (CW+1)'(RATIO))
                   || ((cnt_q == CW'(RATIO-1)) && rd_pend_q && slot_free_w);

    // Reset gating keeps the pop request low while the counters are cleared.
    assign rinc = rrstn && !rempty && !flush_pend_q && !flush && pop_ok_w;

    // A word is complete when the byte captured now fills the last lane, or
    // when a complete word is already being held with cnt == RATIO.
    assign word_full_w = (fill_w == (CW+1)'(RATIO));

    // A flush arriving this cycle is served immediately when possible; the
    // in-flight byte must land first, so service waits for rd_pend to drop.
    assign flush_req_w   = flush || flush_pend_q;
    assign flush_serve_w = flush_req_w && !rd_pend_q && slot_free_w;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        asm_d        = asm_q;
        cnt_d        = cnt_q;
        rd_pend_d    = rinc;
        flush_pend_d = flush_pend_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_keep_d   = out_keep_q;

        // Drop the outgoing word on a handshake; a load below overrides.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        // Capture the returning byte into lane cnt.
        for (int i = 0; i < RATIO; i++) begin
            if (rd_pend_q && (cnt_q == CW'(i))) begin
                asm_d[i] = rdata;
            end
        end

        if (word_full_w && slot_free_w) begin
            out_valid_d = 1'b1;
            out_data_d  = asm_d;
            out_keep_d  = '1;
            cnt_d       = '0;
        end else if (word_full_w) begin
            cnt_d       = CW'(RATIO);
        end else if (flush_serve_w) begin
            // Partial word: only lanes below cnt are meaningful; stale lanes
            // from the previous word are zeroed.
            if (cnt_q != '0) begin
                out_valid_d = 1'b1;
                for (int i = 0; i < RATIO; i++) begin
                    if (CW'(i) < cnt_q) begin
                        out_data_d[i*WIDTH +: WIDTH] = asm_q[i];
                        out_keep_d[i]                = 1'b1;
                    end else begin
                        out_data_d[i*WIDTH +: WIDTH] = '0;
                        out_keep_d[i]                = 1'b0;
                    end
                end
            end
            cnt_d = '0;
        end else begin
            cnt_d = fill_w[CW-1:0];
        end

        if (flush_serve_w) begin
            flush_pend_d = 1'b0;
        end else if (flush) begin
            flush_pend_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge rclk or negedge rrstn) begin
        if (!rrstn) begin
            asm_q        <= '0;
            cnt_q        <= '0;
            rd_pend_q    <= 1'b0;
            flush_pend_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_keep_q   <= '0;
        end else begin
            asm_q        <= asm_d;
            cnt_q        <= cnt_d;
            rd_pend_q    <= rd_pend_d;
            flush_pend_q <= flush_pend_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_keep_q   <= out_keep_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_keep  = out_keep_q;

endmodule : afifo_rd_packer
`default_nettype wire

// File: tb/tb_afifo_rd_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_afifo_rd_packer
// Description : Scoreboard testbench for afifo_rd_packer. A behavioural FIFO
//               with registered read data feeds the DUT; expected words are
//               queued by the stimulus and checked by an independent monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_afifo_rd_packer;

    localparam int W = 8;
    localparam int R = 4;

    typedef struct packed {
        logic [W*R-1:0] d;
        logic [R-1:0]   k;
    } exp_t;

    logic           rclk = 1'b0;
    logic           rrstn;
    logic           rempty;
    logic           rinc;
    logic [W-1:0]   rdata = '0;
    logic           flush;
    logic           out_valid;
    logic           out_ready;
    logic [W*R-1:0] out_data;
    logic [R-1:0]   out_keep;

    afifo_rd_packer #(.WIDTH(W), .RATIO(R)) dut (
        .rclk      (rclk),
        .rrstn     (rrstn),
        .rempty    (rempty),
        .rinc      (rinc),
        .rdata     (rdata),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_keep  (out_keep)
    );

    always #5 rclk = ~rclk;

    // ------------------------------------------------------------------------
    // Behavioural FIFO: registered read data, optional forced-empty toggling
    // ------------------------------------------------------------------------
    logic [W-1:0] mem [0:255];
    int           wr_ptr = 0;
    int           rd_ptr = 0;
    int           pop_count = 0;
    int           cyc = 0;
    logic         hold_empty = 1'b0;
    logic         toggle_en = 1'b0;

    assign rempty = (rd_ptr == wr_ptr) || hold_empty;

    always @(posedge rclk) begin
        cyc <= cyc + 1;
        if (rinc) begin
            rdata     <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
            pop_count <= pop_count + 1;
        end
        hold_empty <= toggle_en ? !hold_empty : 1'b0;
    end

    // ------------------------------------------------------------------------
    // Scoreboard and checking
    // ------------------------------------------------------------------------
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   hs_count = 0;
    int   hs_cyc[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic [W*R-1:0] held_d;
    logic [R-1:0]   held_k;
    logic           held = 1'b0;

    always @(negedge rclk) begin
        if (rrstn) begin
            if (rempty) chk("rinc_while_empty", {63'd0, rinc}, 64'd0);
            if (held && out_valid) begin
                chk("stall_data_stable", {32'd0, out_data}, {32'd0, held_d});
                chk("stall_keep_stable", {60'd0, out_keep}, {60'd0, held_k});
            end
            held   = out_valid && !out_ready;
            held_d = out_data;
            held_k = out_keep;
            if (out_valid && out_ready) begin
                exp_t e;
                hs_count++;
                hs_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_word: got 0x%0h keep 0x%0h, expected no word", out_data, out_keep);
                end else begin
                    e = sb.pop_front();
                    chk("word_data", {32'd0, out_data}, {32'd0, e.d});
                    chk("word_keep", {60'd0, out_keep}, {60'd0, e.k});
                end
            end
        end else begin
            held = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 ns after the rising edge)
    // ------------------------------------------------------------------------
    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] b);
        mem[wr_ptr] = b;
        wr_ptr++;
    endtask

    task automatic expect_word(input logic [W*R-1:0] d, input logic [R-1:0] k);
        exp_t e;
        e.d = d;
        e.k = k;
        sb.push_back(e);
    endtask

    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sb.size() == 0) break;
            tick();
        end
        chk(name, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        logic [9:0] pat;
        int         base;

        // ---------------- Reset with data already waiting ----------------
        rrstn     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push(8'((i << 4) | i));   // 0x11..0x88
        repeat (3) tick();
        chk("reset_rinc",      {63'd0, rinc},      64'd0);
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_out_data",  {32'd0, out_data},  64'd0);
        chk("reset_out_keep",  {60'd0, out_keep},  64'd0);

        // ---------------- Full rate ----------------
        out_ready = 1'b1;
        expect_word(32'h4433_2211, 4'hF);
        expect_word(32'h8877_6655, 4'hF);
        hs_cyc.delete();
        rrstn = 1'b1;
        pat = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge rclk);
            pat = {pat[8:0], rinc};
        end
        chk("fullrate_rinc_pattern", {54'd0, pat}, {54'd0, 10'b11_1111_1100});
        drain("fullrate_drain", 20);
        if (hs_cyc.size() >= 2)
            chk("fullrate_word_spacing", 64'(hs_cyc[1] - hs_cyc[0]), 64'd4);
        else
            chk("fullrate_word_count", 64'(hs_cyc.size()), 64'd2);

        // ---------------- Backpressure ----------------
        out_ready = 1'b0;
        base = pop_count;
        for (int i = 0; i < 12; i++) push(8'(8'h21 + i));
        expect_word(32'h2423_2221, 4'hF);
        expect_word(32'h2827_2625, 4'hF);
        expect_word(32'h2C2B_2A29, 4'hF);
        repeat (20) tick();
        chk("bp_pop_count",  64'(pop_count - base), 64'd8);
        chk("bp_rinc_low",   {63'd0, rinc},      64'd0);
        chk("bp_out_valid",  {63'd0, out_valid}, 64'd1);
        chk("bp_out_data",   {32'd0, out_data},  64'h2423_2221);
        out_ready = 1'b1;
        drain("bp_drain", 30);

        // ---------------- Flush partial word ----------------
        push(8'hA1);
        push(8'hA2);
        push(8'hA3);
        expect_word(32'h00A3_A2A1, 4'b0111);
        repeat (8) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drain("flush_drain", 10);
        base = hs_count;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (6) tick();
        chk("flush_empty_no_output", 64'(hs_count - base), 64'd0);

        // ---------------- Empty toggling ----------------
        toggle_en = 1'b1;
        for (int i = 0; i < 8; i++) push(8'(8'h31 + i));
        expect_word(32'h3433_3231, 4'hF);
        expect_word(32'h3837_3635, 4'hF);
        drain("toggle_drain", 60);
        toggle_en = 1'b0;
        tick();

        // ---------------- Reset mid-word ----------------
        push(8'h55);
        push(8'h66);
        repeat (6) tick();
        rrstn = 1'b0;
        tick();
        chk("midreset_rinc",      {63'd0, rinc},      64'd0);
        chk("midreset_out_valid", {63'd0, out_valid}, 64'd0);
        tick();
        rrstn = 1'b1;
        for (int i = 1; i <= 4; i++) push(8'(i));
        expect_word(32'h0403_0201, 4'hF);
        drain("midreset_drain", 20);
        repeat (4) tick();

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_afifo_rd_packer
`default_nettype wire

// File: doc/afifo_rd_packer.md
# afifo_rd_packer

Read-side consumer of the asynchronous FIFO, running entirely in the FIFO read clock domain. It drives the FIFO pop (`rinc`), captures `WIDTH`-bit entries from the FIFO's registered RAM output, and packs `RATIO` consecutive entries little-endian into one word. Words leave on a valid/ready stream. A flush request emits a partial word with a lane-keep mask.

## Interface
- `WIDTH`, 8 — FIFO entry width in bits.
- `RATIO`, 4 — entries per output word; must be ≥ 2.
- `rclk` in 1 — read-domain clock. Single clock; all logic is on its rising edge.
- `rrstn` in 1 — reset, asynchronous, active-low.
- `rempty` in 1 — FIFO empty flag.
- `rinc` out 1 — FIFO pop request. Combinational.
- `rdata` in `WIDTH` — FIFO read data. Valid the cycle after an accepted pop.
- `flush` in 1 — single-cycle request to emit the partial word.
- `out_valid` out 1 — output word valid.
- `out_ready` in 1 — downstream accept.
- `out_data` out `WIDTH*RATIO` — packed word; lane 0 is in the LSBs.
- `out_keep` out `RATIO` — lane valid mask.

## Operation
- **State**
  - `cnt` (0..`RATIO`): lanes filled in the assembly register.
  - `rd_pend`: a pop was accepted last cycle, so `rdata` carries a byte this cycle.
  - `flush_pend`: a flush is pending.
  - Output register: `out_valid`, `out_data`, `out_keep`.
- **Slot free:** `slot_free = !out_valid || out_ready`.
- **Pop rule.** `rinc = !rempty && !flush_pend && !flush && (cnt + rd_pend < RATIO || (cnt == RATIO-1 && rd_pend && slot_free))`.
  - `rinc` is never asserted while `rempty` = 1.
  - There is a combinational path from `out_ready` to `rinc`.
- **Capture.** When `rd_pend` = 1, `rdata` is written into lane `cnt` and `cnt` increments.
- **Word complete.** The word is complete when the captured byte fills lane `RATIO-1`, or when `cnt` = `RATIO` is being held.
  - If `slot_free`: the word loads the output register with `out_keep` = all ones, and `cnt` becomes 0 on the same edge.
  - Otherwise the word is held with `cnt` = `RATIO`. No pops occur until it loads.
- **Flush.**
  - `flush` = 1 sets `flush_pend`. A `flush` arriving while `flush_pend` is already set is ignored.
  - Once `rd_pend` = 0 and `slot_free`:
    - if `cnt` > 0, load the output with lanes `0..cnt-1` filled, `out_keep` = `(1<<cnt)-1`, unused lanes zero;
    - then clear `cnt` and `flush_pend`.
  - If `cnt` = 0, `flush_pend` clears with no output.
  - If `cnt` = `RATIO` when the flush is served, the full word is emitted as normal.
- **Output stream.**
  - `out_data` and `out_keep` hold stable while `out_valid && !out_ready`.
  - `out_ready` is ignored while `out_valid` = 0.
  - `out_valid` clears on a handshake unless a new word loads on the same edge.
- **Width and order rules.**
  - `cnt` is `$clog2(RATIO+1)` bits wide.
  - Bytes are never dropped, duplicated or reordered.

## Timing
- **Reset values:** `out_valid` = 0, `out_data` = 0, `out_keep` = 0, `cnt` = 0, `rd_pend` = 0, `flush_pend` = 0.
  - `rinc` = 0 while `rrstn` is low.
  - Reset mid-word discards the partial word. The next byte lands in lane 0.
- **Data latency:** a pop at cycle t delivers its byte on `rdata` at t+1, and it is captured at the end of t+1.
  - The last byte of a word popped at t gives `out_valid` = 1 at t+2.
- **Throughput:** one byte per cycle sustained while `rempty` = 0 and `out_ready` = 1. No bubble at word boundaries.
- **Backpressure:** at most `RATIO` bytes are buffered beyond the output register.
- **Flush latency:** a flush at t with `rd_pend` = 0 and a free slot gives `out_valid` at t+1. With `rd_pend` = 1 it gives `out_valid` at t+2, and the in-flight byte is included.

## Structure
- A shared package `afifo_pkg` holds the default `WIDTH`/`RATIO` constants and the `cnt` width function.
- The block is one flat module. No sub-module is natural; the assembly register and the output register are inline.

## Test plan
- **Reset:** `rrstn` = 0 with `rempty` = 0 → `rinc` = 0, `out_valid` = 0, `out_data` = 0, `out_keep` = 0.
- **Full rate:** FIFO preloaded with 0x11..0x88, `out_ready` = 1 → `rinc` high 8 consecutive cycles. Outputs are 0x44332211 then 0x88776655, `out_keep` = 4'hF, with no gap cycle between words.
- **Backpressure:** `out_ready` = 0 after the first word → exactly 4 more pops, then `rinc` = 0. `out_data` stays stable. On release, words emerge in order with no loss.
- **Flush:** bytes 0xA1, 0xA2, 0xA3, then `flush` → `out_data` = 0x00A3A2A1, `out_keep` = 4'b0111. A second flush with `cnt` = 0 → no output.
- **Empty handling:** `rempty` toggling every cycle → `rinc` never 1 while `rempty` = 1. Packed words are correct.
- **Reset mid-word:** `rrstn` pulse at `cnt` = 2 → next bytes 0x01..0x04 give 0x04030201.
